fetch_stage_hs: RTL
===================

// Module: fetch_stage_hs
// PURPOSE
//  Parametrised IF stage with IF/ID pipeline register. Fetches from an instruction memory
//  through a valid/ready request and valid response handshake. The memory latency is variable.
//  Supports a branch/jump redirect from EX, a stall from the hazard unit and an IF/ID flush.
//  Sits between imem and the decode cycle; at most one request is outstanding at a time.
// PARAMETERS
//  XLEN      32            address/data width of PC and instruction
//  RESET_PC  32'h00000000  PC fetched first after reset
//  NOP_INSTR 32'h00000013  bubble encoding driven on instr_d (addi x0,x0,0)
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous reset, active-low
//  pc_target_e     in   XLEN  redirect target from EX
//  pc_src_e        in   1     redirect request (taken branch/jump)
//  stall_d         in   1     hold IF/ID and PC (load-use hazard)
//  flush_d         in   1     replace IF/ID contents with bubble
//  imem_req_valid  out  1     request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address (= pc_f)
//  imem_rsp_valid  in   1     response valid, one per accepted request, in order
//  imem_rsp_data   in   XLEN  fetched instruction
//  instr_d         out  XLEN  IF/ID instruction
//  pc_d            out  XLEN  IF/ID PC
//  pc_plus4_d      out  XLEN  IF/ID PC+4
//  valid_d         out  1     IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst=0, async): pc_f=RESET_PC, state=REQ, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0,
//   valid_d=0, hold register cleared. imem_req_valid=0 while rst=0.
//  imem_req_valid=1 only in REQ; imem_req_addr=pc_f, registered with no comb path from pc_src_e.
//  "Deliver" means: IF/ID <= {data, pc_f, pc_f+4 (mod 2^XLEN), valid=1}; pc_f <= pc_f+4; -> REQ.
//  "Blocked" means stall_d=1 or flush_d=1.
//  States:
//   REQ : on req_valid&req_ready -> WAIT (-> DROP if pc_src_e same cycle).
//         pc_src_e: pc_f <= pc_target_e.
//   WAIT: rsp_valid&!pc_src_e&!blocked: deliver.
//         rsp_valid&!pc_src_e&blocked: data -> hold reg, -> HOLD.
//         rsp_valid&pc_src_e: discard, pc_f<=target, -> REQ.
//         !rsp_valid&pc_src_e: pc_f<=target, -> DROP.
//   HOLD: !blocked&!pc_src_e: deliver from hold reg.
//         pc_src_e: discard, pc_f<=target, -> REQ.
//   DROP: rsp_valid: discard, -> REQ. pc_src_e: pc_f<=target, stay DROP.
//  IF/ID priority: flush_d (bubble: NOP_INSTR, valid_d=0, pc_d/pc_plus4_d=0) > stall_d (hold) >
//   deliver > else bubble (valid_d=0, instr_d=NOP_INSTR) when nothing delivered.
//  Redirect always wins over pending data; wrong-path instruction never reaches valid_d=1.
//  Fetch latency: req handshake at cycle N, rsp at N+k, valid_d=1 at N+k+1; best case 1 instr/2 clk.
//  PC wraps 2^XLEN-4 -> 0 without error. Reset mid-transaction: late rsp after reset is a
//   memory-side violation; the memory is reset alongside.
// TESTING
//  Reset, req_ready=1, rsp one cycle later, data 0xA: instr_d=0xA, pc_d=0, pc_plus4_d=4, valid_d=1;
//   next req addr=4.
//  req_ready low 3 cycles: req_valid stays 1 and addr stays 0; no PC advance.
//  stall_d=1 when rsp 0xB arrives: IF/ID unchanged, HOLD. stall_d=0: instr_d=0xB, req addr=+4.
//  pc_src_e=1, target 0x100, in WAIT before rsp: rsp data dropped, valid_d stays 0,
//   next req addr=0x100.
//  flush_d=1&pc_src_e=1 with rsp same cycle: valid_d=0, instr_d=0x13, next req addr=target.
//  RESET_PC=0xFFFFFFFC: first deliver gives pc_d=0xFFFFFFFC, pc_plus4_d=0, next req addr=0.

Source files
------------

// File: rtl/fetch_stage_hs.sv
// ============================================================================
// Module   : fetch_stage_hs
// Purpose  : IF stage with IF/ID register; one-outstanding valid/ready imem fetch
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage_hs #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            pc_src_e,
    input  logic            stall_d,
    input  logic            flush_d,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state;
    logic            reqValid;
    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] holdData;

    logic            blocked;
    logic            deliver;
    logic [XLEN-1:0] deliverData;
    logic [XLEN-1:0] pcPlus4F;

    assign blocked     = stall_d | flush_d;
    assign deliver     = !pc_src_e && !blocked &&
                         ((state == S_WAIT && imem_rsp_valid) || state == S_HOLD);
    assign deliverData = (state == S_HOLD) ? holdData : imem_rsp_data;
    assign pcPlus4F    = pcF + XLEN'(4);

    // Request valid is a flop so it stays low through reset and never sees pc_src_e combinationally.
    assign imem_req_valid = reqValid;
    assign imem_req_addr  = pcF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            reqValid <= 1'b0;
            pcF      <= RESET_PC;
            holdData <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (reqValid && imem_req_ready) begin
                        reqValid <= 1'b0;
                        state    <= pc_src_e ? S_DROP : S_WAIT;
                    end else begin
                        reqValid <= 1'b1;
                    end
                    if (pc_src_e) pcF <= pc_target_e;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (pc_src_e) begin
                            pcF      <= pc_target_e;
                            state    <= S_REQ;
                            reqValid <= 1'b1;
                        end else if (blocked) begin
                            holdData <= imem_rsp_data;
                            state    <= S_HOLD;
                        end else begin
                            pcF      <= pcPlus4F;
                            state    <= S_REQ;
                            reqValid <= 1'b1;
                        end
                    end else if (pc_src_e) begin
                        pcF   <= pc_target_e;
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (pc_src_e) begin
                        pcF      <= pc_target_e;
                        state    <= S_REQ;
                        reqValid <= 1'b1;
                    end else if (!blocked) begin
                        pcF      <= pcPlus4F;
                        state    <= S_REQ;
                        reqValid <= 1'b1;
                    end
                end
                S_DROP: begin
                    // The stale response still owed by memory is swallowed here.
                    if (pc_src_e) pcF <= pc_target_e;
                    if (imem_rsp_valid) begin
                        state    <= S_REQ;
                        reqValid <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    reqValid <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush_d) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (stall_d) begin
            valid_d    <= valid_d;
        end else if (deliver) begin
            instr_d    <= deliverData;
            pc_d       <= pcF;
            pc_plus4_d <= pcPlus4F;
            valid_d    <= 1'b1;
        end else begin
            instr_d    <= NOP_INSTR;
            valid_d    <= 1'b0;
        end
    end

endmodule

`default_nettype wire
